expr_pipe_eval: RTL and testbench



---
 rtl/expr_pipe_eval.sv | 153 +++++++++++++++
 tb/tb_expr_pipe_eval.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_pipe_eval.sv
// Two-stage valid/ready pipeline of NCH mixed-signedness expression channels.
// Optional build macro EXPR_PIPE_SAT_EN clamps ADD/SUB instead of wrapping.
module expr_pipe_eval #(
  parameter int           NCH         = 6,
  parameter int           W           = 6,
  parameter logic [NCH-1:0] SIGNED_MASK = 6'b111000,
  parameter int           CW          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCH*W-1:0] a,
  input  logic [NCH*W-1:0] b,
  input  logic [3*NCH-1:0] op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NCH*W-1:0] y,
  input  logic             ovf_clr,
  output logic [CW-1:0]    ovf_cnt
);

  localparam int SW = $clog2(W);
  localparam int PW = $clog2(NCH + 1);
  localparam int TW = ((CW > PW) ? CW : PW) + 1;

  logic             s1_valid;
  logic             s2_valid;
  logic             s2_load;
  logic [NCH*W-1:0] s1_a;
  logic [NCH*W-1:0] s1_b;
  logic [3*NCH-1:0] s1_op;
  logic [NCH*W-1:0] res;
  logic [NCH-1:0]   ovf;
  logic [PW-1:0]    pc;
  logic [TW-1:0]    cnt_sum;
  logic [CW-1:0]    cnt_nxt;

  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_load;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam int LO = (NCH - 1 - i) * W;
    localparam bit SG = SIGNED_MASK[i];

    logic [W-1:0] ca;
    logic [W-1:0] cb;
    logic [2:0]   co;
    logic [W:0]   sum;
    logic [W:0]   dif;
    logic         v_add;
    logic         v_sub;
    logic         lt;
    logic [W-1:0] sra;
    logic [W-1:0] shr_r;
    logic [W-1:0] add_r;
    logic [W-1:0] sub_r;
    logic [W-1:0] r;

    assign ca  = s1_a[LO +: W];
    assign cb  = s1_b[LO +: W];
    assign co  = s1_op[(NCH-1-i)*3 +: 3];
    assign sum = {1'b0, ca} + {1'b0, cb};
    assign dif = {1'b0, ca} - {1'b0, cb};

    assign v_add = SG ? ((ca[W-1] == cb[W-1]) && (sum[W-1] != ca[W-1]))
                      : sum[W];
    assign v_sub = SG ? ((ca[W-1] != cb[W-1]) && (dif[W-1] != ca[W-1]))
                      : dif[W];
    assign lt    = SG ? ($signed(ca) < $signed(cb)) : (ca < cb);

    // kept separate so the signed shift is not unsigned-ified by a ternary
    assign sra   = $signed(ca) >>> cb[SW-1:0];
    assign shr_r = SG ? sra : (ca >> cb[SW-1:0]);

`ifdef EXPR_PIPE_SAT_EN
    localparam logic [W-1:0] MAXV = SG ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}};
    localparam logic [W-1:0] MINV = SG ? {1'b1, {(W-1){1'b0}}} : '0;

    assign add_r = !v_add ? sum[W-1:0]
                 : (SG && ca[W-1]) ? MINV : MAXV;
    assign sub_r = !v_sub ? dif[W-1:0]
                 : (SG && !ca[W-1]) ? MAXV : MINV;
`else
    assign add_r = sum[W-1:0];
    assign sub_r = dif[W-1:0];
`endif

    always_comb begin
      r = '0;
      unique case (co)
        3'd0: r = add_r;
        3'd1: r = sub_r;
        3'd2: r = ca & cb;
        3'd3: r = ca ~^ cb;
        3'd4: r = {{(W-1){1'b0}}, lt};
        3'd5: r = {{(W-1){1'b0}}, ca !== cb};
        3'd6: r = {{(W-1){1'b0}}, ^(ca & cb)};
        3'd7: r = shr_r;
      endcase
    end

    assign res[LO +: W] = r;
    assign ovf[i] = ((co == 3'd0) && v_add) || ((co == 3'd1) && v_sub);
  end

  always_comb begin
    pc = '0;
    for (int k = 0; k < NCH; k++) pc = pc + PW'(ovf[k]);
  end

  assign cnt_sum = TW'(ovf_cnt) + TW'(pc);
  assign cnt_nxt = (cnt_sum > TW'({CW{1'b1}})) ? {CW{1'b1}}
                                                : cnt_sum[CW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      y        <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) y <= res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (s2_load && s1_valid) begin
      ovf_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_expr_pipe_eval.sv
// Directed bench for expr_pipe_eval: default instance plus a CW=2 instance
// that shares stimulus to exercise counter saturation.
module tb_expr_pipe_eval;

  localparam int NCH = 6;
  localparam int W   = 6;
`ifdef EXPR_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             out_ready;
  logic [NCH*W-1:0] a_v;
  logic [NCH*W-1:0] b_v;
  logic [3*NCH-1:0] op_v;
  logic             clr0;
  logic             clr1;

  logic             in_ready0, out_valid0;
  logic [NCH*W-1:0] y0;
  logic [7:0]       cnt0;
  logic             in_ready1, out_valid1;
  logic [NCH*W-1:0] y1;
  logic [1:0]       cnt1;

  int nchk  = 0;
  int npass = 0;

  always #5 clk = ~clk;

  expr_pipe_eval u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0),
    .a(a_v), .b(b_v), .op(op_v),
    .out_valid(out_valid0), .out_ready(out_ready),
    .y(y0), .ovf_clr(clr0), .ovf_cnt(cnt0)
  );

  expr_pipe_eval #(.CW(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1),
    .a(a_v), .b(b_v), .op(op_v),
    .out_valid(out_valid1), .out_ready(out_ready),
    .y(y1), .ovf_clr(clr1), .ovf_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else
      npass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [2:0] o,
                        input logic [5:0] av, input logic [5:0] bv);
    a_v[(NCH-1-i)*W +: W]  = av;
    b_v[(NCH-1-i)*W +: W]  = bv;
    op_v[(NCH-1-i)*3 +: 3] = o;
  endtask

  task automatic idle();
    for (int i = 0; i < NCH; i++) set_ch(i, 3'd2, 6'd0, 6'd0);
  endtask

  task automatic fill(input logic [5:0] v);
    for (int i = 0; i < NCH; i++) set_ch(i, 3'd2, v, v);
  endtask

  task automatic issue();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  function automatic logic [35:0] pk(input logic [5:0] c0, c1, c2,
                                     c3, c4, c5);
    return {c0, c1, c2, c3, c4, c5};
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    clr0 = 1'b0; clr1 = 1'b0;
    a_v = '0; b_v = '0; op_v = '0;
    idle();
    #3;
    chk("rst_ov", out_valid0, 0);
    chk("rst_y", y0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_rdy", in_ready0, 1);
    step(); step();
    chk("rst_rdy_hold", in_ready0, 1);
    #3 rst_n = 1'b1;
    step();

    // unsigned ADD wrap on ch0, latency 2
    idle();
    set_ch(0, 3'd0, 6'd63, 6'd1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_lat1", out_valid0, 0);
    step();
    chk("t1_ov", out_valid0, 1);
    chk("t1_y", y0, pk(SAT ? 6'h3F : 6'h00, 0, 0, 0, 0, 0));
    chk("t1_cnt", cnt0, 1);
    step();
    chk("t1_drain", out_valid0, 0);

    // signed ADD overflow on ch5
    idle();
    set_ch(5, 3'd0, 6'd31, 6'd1);
    issue();
    chk("t2_y", y0, pk(0, 0, 0, 0, 0, SAT ? 6'h1F : 6'h20));
    chk("t2_cnt", cnt0, 2);
    step();

    // LT signedness plus XNOR/NE/RXOR and signed SUB overflow
    idle();
    set_ch(0, 3'd4, 6'h3F, 6'h01);
    set_ch(1, 3'd3, 6'h0F, 6'h33);
    set_ch(2, 3'd5, 6'h05, 6'h05);
    set_ch(3, 3'd4, 6'h3F, 6'h01);
    set_ch(4, 3'd6, 6'h3F, 6'h07);
    set_ch(5, 3'd1, 6'h20, 6'h01);
    issue();
    chk("t3a_y", y0, pk(6'h00, 6'h03, 6'h00, 6'h01, 6'h01,
                        SAT ? 6'h20 : 6'h1F));
    chk("t3a_cnt", cnt0, 3);
    step();

    // SHR signedness plus unsigned borrow, plain ADD, signed SUB, NE
    idle();
    set_ch(0, 3'd7, 6'h3F, 6'h01);
    set_ch(1, 3'd1, 6'h00, 6'h01);
    set_ch(2, 3'd0, 6'd10, 6'd5);
    set_ch(3, 3'd7, 6'h3F, 6'h01);
    set_ch(4, 3'd1, 6'd5, 6'd10);
    set_ch(5, 3'd5, 6'd1, 6'd2);
    issue();
    chk("t3b_y", y0, pk(6'h1F, SAT ? 6'h00 : 6'h3F, 6'h0F, 6'h3F,
                        6'h3B, 6'h01));
    chk("t3b_cnt", cnt0, 4);
    step();

    // backpressure: three offered, two taken, order kept
    out_ready = 1'b0;
    fill(6'h11);
    in_valid = 1'b1;
    #1;
    chk("bp_rdy0", in_ready0, 1);
    step();
    chk("bp_rdy1", in_ready0, 1);
    chk("bp_ov1", out_valid0, 0);
    fill(6'h22);
    step();
    chk("bp_ov2", out_valid0, 1);
    chk("bp_y2", y0, {6{6'h11}});
    chk("bp_rdy2", in_ready0, 0);
    fill(6'h33);
    step();
    chk("bp_rdy3", in_ready0, 0);
    chk("bp_y3", y0, {6{6'h11}});
    step();
    chk("bp_y4", y0, {6{6'h11}});
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_rel", in_ready0, 1);
    step();
    in_valid = 1'b0;
    chk("bp_ovY", out_valid0, 1);
    chk("bp_yY", y0, {6{6'h22}});
    step();
    chk("bp_ovZ", out_valid0, 1);
    chk("bp_yZ", y0, {6{6'h33}});
    step();
    chk("bp_empty", out_valid0, 0);
    chk("bp_cnt", cnt0, 4);

    // four overflows in one result: saturation at CW=2
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    chk("sat_clr", cnt1, 0);
    idle();
    set_ch(0, 3'd0, 6'd63, 6'd1);
    set_ch(1, 3'd0, 6'd63, 6'd63);
    set_ch(2, 3'd1, 6'd0, 6'd1);
    set_ch(3, 3'd0, 6'd31, 6'd1);
    issue();
    chk("sat_y", y0, SAT ? pk(6'h3F, 6'h3F, 6'h00, 6'h1F, 0, 0)
                         : pk(6'h00, 6'h3E, 6'h3F, 6'h20, 0, 0));
    chk("sat_cnt8", cnt0, 8);
    chk("sat_cnt2", cnt1, 3);
    step();

    // clear wins over a same-cycle overflow increment
    idle();
    set_ch(0, 3'd0, 6'd63, 6'd1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    clr0 = 1'b1; clr1 = 1'b1;
    step();
    clr0 = 1'b0; clr1 = 1'b0;
    chk("clr_ov", out_valid0, 1);
    chk("clr_cnt0", cnt0, 0);
    chk("clr_cnt1", cnt1, 0);
    step();
    chk("clr_hold", cnt0, 0);

    // reset with both stages full
    out_ready = 1'b0;
    idle();
    set_ch(0, 3'd0, 6'd63, 6'd1);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("mr_ov", out_valid0, 1);
    chk("mr_cnt", cnt0, 1);
    chk("mr_full", in_ready0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ov0", out_valid0, 0);
    chk("mr_y0", y0, 0);
    chk("mr_cnt0", cnt0, 0);
    chk("mr_rdy", in_ready0, 1);
    #2 out_ready = 1'b1;
    #1 rst_n = 1'b1;
    step();
    chk("mr_stale1", out_valid0, 0);
    step();
    chk("mr_stale2", out_valid0, 0);
    chk("mr_rdy2", in_ready0, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
